// File: rtl/accel_feeder_pkg.sv
// Shared types and sizing helpers for the systolic operand feeder.
package accel_feeder_pkg;

  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } feeder_state_t;

  typedef logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_vec_t;

  function automatic int unsigned drain_cnt_width(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  localparam int unsigned DRAIN_CNT_W = drain_cnt_width(NUM_LANES);

endpackage

// File: rtl/operand_skew_feeder_sync_fifo.sv
// Single-clock FIFO with registered occupancy; push is refused while full.
module sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AddrW-1:0] wptr;
  logic [AddrW-1:0] rptr;
  logic [AddrW:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AddrW+1)'(Depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AddrW'(1);
      if (do_pop)  rptr <= rptr + AddrW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AddrW+1)'(1);
        2'b01:   count <= count - (AddrW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/operand_skew_feeder.sv
// Buffers operand vectors, streams one tile per start, then flushes the skew chains.
module operand_skew_feeder
  import accel_feeder_pkg::*;
#(
  parameter int unsigned NumLanes     = 4,
  parameter int unsigned DataWidth    = 8,
  parameter int unsigned FifoDepth    = 4,
  parameter int unsigned TileLenWidth = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [TileLenWidth-1:0]       tile_len_i,
  output logic                          busy_o,
  output logic                          done_o,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [NumLanes*DataWidth-1:0] in_data_i,
  output logic                          out_valid_o,
  output logic [NumLanes*DataWidth-1:0] out_data_o,
  output logic                          out_last_o
);

  localparam int unsigned VecW   = NumLanes * DataWidth;
  localparam int unsigned DrainW = drain_cnt_width(NumLanes);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(NumLanes - 1);
  // Zero-length tiles enter DRAIN without a last-vector cycle, so skip one count.
  localparam logic [DrainW-1:0] DrainZeroStart = (NumLanes > 1) ? DrainW'(1) : '0;

  feeder_state_t           state;
  feeder_state_t           state_next;
  logic [TileLenWidth-1:0] tile_len;
  logic [TileLenWidth-1:0] emit_cnt;
  logic [TileLenWidth-1:0] emit_next;
  logic [DrainW-1:0]       drain_cnt;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [VecW-1:0]         head;
  logic                    pop;
  logic                    last_pop;
  logic                    drain_end;

  sync_fifo #(
    .Width(VecW),
    .Depth(FifoDepth)
  ) u_fifo (
    .clk  (clk_i),
    .rst  (rst_i),
    .push (in_valid_i),
    .pop  (pop),
    .wdata(in_data_i),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign in_ready_o = !fifo_full;
  assign busy_o     = (state != IDLE);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    last_pop   = 1'b0;
    drain_end  = 1'b0;
    emit_next  = emit_cnt + TileLenWidth'(1);
    case (state)
      IDLE: begin
        if (start_i) state_next = (tile_len_i != '0) ? STREAM : DRAIN;
      end
      STREAM: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (emit_next == tile_len) begin
            last_pop   = 1'b1;
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == DrainLast) begin
          drain_end  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      tile_len    <= '0;
      emit_cnt    <= '0;
      drain_cnt   <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state       <= state_next;
      out_valid_o <= pop;
      out_data_o  <= pop ? head : '0;
      out_last_o  <= last_pop;
      done_o      <= drain_end;
      if (state == IDLE && start_i) begin
        tile_len  <= tile_len_i;
        emit_cnt  <= '0;
        drain_cnt <= (tile_len_i == '0) ? DrainZeroStart : '0;
      end
      if (pop)            emit_cnt  <= emit_next;
      if (last_pop)       drain_cnt <= '0;
      if (state == DRAIN) drain_cnt <= drain_cnt + DrainW'(1);
    end
  end

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Directed bench for operand_skew_feeder with hand-computed expectations.
module tb_operand_skew_feeder;
  import accel_feeder_pkg::*;

  localparam int unsigned NL = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned VW = NL * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    tile_len;
  logic          busy;
  logic          done;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic          out_valid;
  logic [VW-1:0] out_data;
  logic          out_last;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  operand_skew_feeder #(
    .NumLanes(NL),
    .DataWidth(DW),
    .FifoDepth(4),
    .TileLenWidth(8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .tile_len_i (tile_len),
    .busy_o     (busy),
    .done_o     (done),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_last_o (out_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bp_vec(input int unsigned i);
    lane_vec_t v;
    for (int unsigned l = 0; l < NL; l++) v[l] = 8'(16 * l + i + 1);
    return v;
  endfunction

  task automatic expect_out(input string tag, input logic v, input logic [31:0] d,
                            input logic l, input logic dn);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_data"},  out_data, d);
    check({tag, "_last"},  32'(out_last), 32'(l));
    check({tag, "_done"},  32'(done), 32'(dn));
  endtask

  task automatic push_one(input string tag, input logic [31:0] v);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = v;
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic start_tile(input string tag, input logic [7:0] len);
    start    = 1'b1;
    tile_len = len;
    step();
    start    = 1'b0;
    tile_len = '0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic drain_done(input string tag);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out({tag, "_drain"}, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    step();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    step();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic basic_tile(input string tag);
    push_one(tag, 32'h04030201);
    push_one(tag, 32'h08070605);
    push_one(tag, 32'h0C0B0A09);
    start_tile(tag, 8'd3);
    step(); expect_out({tag, "_v0"}, 1'b1, 32'h04030201, 1'b0, 1'b0);
    step(); expect_out({tag, "_v1"}, 1'b1, 32'h08070605, 1'b0, 1'b0);
    step(); expect_out({tag, "_v2"}, 1'b1, 32'h0C0B0A09, 1'b1, 1'b0);
    drain_done(tag);
  endtask

  initial begin
    int unsigned k;
    int unsigned n_out;
    int unsigned dones;
    int unsigned valids;
    logic        ready_back;
    logic        acc;

    rst = 1'b1; start = 1'b0; tile_len = '0; in_valid = 1'b0; in_data = '0;
    step(); step();
    expect_out("reset", 1'b0, 32'h0, 1'b0, 1'b0);
    check("reset_busy",  32'(busy), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    step();

    basic_tile("basic");

    // Starvation: second vector arrives five cycles after the first.
    start_tile("starve", 8'd2);
    in_valid = 1'b1; in_data = 32'hAABBCCDD;
    step(); in_valid = 1'b0; in_data = '0;
    expect_out("starve_lat", 1'b0, 32'h0, 1'b0, 1'b0);
    step(); expect_out("starve_a", 1'b1, 32'hAABBCCDD, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("starve_gap", 1'b0, 32'h0, 1'b0, 1'b0);
    end
    in_valid = 1'b1; in_data = 32'h11223344;
    step(); in_valid = 1'b0; in_data = '0;
    expect_out("starve_gap2", 1'b0, 32'h0, 1'b0, 1'b0);
    step(); expect_out("starve_b", 1'b1, 32'h11223344, 1'b1, 1'b0);
    drain_done("starve");

    // Backpressure: prefill in IDLE, then stream six vectors.
    k = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = bp_vec(k);
      acc      = in_ready;
      step();
      if (acc) k++;
    end
    check("bp_accepts", k, 32'd4);
    check("bp_full_ready", 32'(in_ready), 32'd0);
    n_out = 0; dones = 0; ready_back = 1'b0;
    start = 1'b1; tile_len = 8'd6;
    for (int c = 0; c < 20; c++) begin
      in_valid = (k < 6);
      in_data  = bp_vec(k);
      acc      = in_valid && in_ready;
      step();
      start = 1'b0;
      if (acc) k++;
      if (in_ready) ready_back = 1'b1;
      if (out_valid) begin
        check("bp_data", out_data, bp_vec(n_out));
        check("bp_last", 32'(out_last), 32'(n_out == 5));
        n_out++;
      end else begin
        check("bp_bubble", out_data, 32'h0);
      end
      if (done) dones++;
    end
    in_valid = 1'b0; in_data = '0;
    check("bp_ready_back", 32'(ready_back), 32'd1);
    check("bp_count", n_out, 32'd6);
    check("bp_pushed", k, 32'd6);
    check("bp_dones", dones, 32'd1);

    // Zero-length tile leaves buffered data untouched.
    push_one("zero", 32'h5A5A0001);
    push_one("zero", 32'h5A5A0002);
    start_tile("zero", 8'd0);
    valids = 0; dones = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (out_valid) valids++;
      if (done) dones++;
      if (c == 3) check("zero_done_at", 32'(done), 32'd1);
    end
    check("zero_valids", valids, 32'd0);
    check("zero_dones", dones, 32'd1);
    start_tile("zero_next", 8'd2);
    step(); expect_out("zero_keep0", 1'b1, 32'h5A5A0001, 1'b0, 1'b0);
    step(); expect_out("zero_keep1", 1'b1, 32'h5A5A0002, 1'b1, 1'b0);
    drain_done("zero_next");

    // Reset mid-tile.
    push_one("rst", 32'hDEAD0001);
    push_one("rst", 32'hDEAD0002);
    push_one("rst", 32'hDEAD0003);
    start_tile("rst", 8'd5);
    step(); expect_out("rst_v0", 1'b1, 32'hDEAD0001, 1'b0, 1'b0);
    step(); expect_out("rst_v1", 1'b1, 32'hDEAD0002, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_out("rst_mid", 1'b0, 32'h0, 1'b0, 1'b0);
    check("rst_mid_busy",  32'(busy), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    dones = 0; valids = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (done) dones++;
      if (out_valid) valids++;
    end
    check("rst_no_done", dones, 32'd0);
    check("rst_no_valid", valids, 32'd0);
    basic_tile("rst_fresh");

    // start during STREAM is ignored.
    push_one("ign", 32'h0F0F0001);
    push_one("ign", 32'h0F0F0002);
    push_one("ign", 32'h0F0F0003);
    start_tile("ign", 8'd3);
    start = 1'b1; tile_len = 8'd9;
    step();
    start = 1'b0; tile_len = '0;
    expect_out("ign_v0", 1'b1, 32'h0F0F0001, 1'b0, 1'b0);
    valids = 1; dones = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (out_valid) valids++;
      if (done) dones++;
    end
    check("ign_valids", valids, 32'd3);
    check("ign_dones", dones, 32'd1);
    check("ign_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/operand_skew_feeder.md
Name: operand_skew_feeder

Overview:
- Upstream stage of the systolic array's per-lane skew register chains.
- Accepts NumLanes-wide operand vectors over a valid/ready stream and buffers them in a small FIFO.
- Emits one vector per cycle for a programmed tile length, then injects NumLanes-1 zero flush cycles so the downstream skew chains drain completely.
- The downstream chains have no backpressure, so this block absorbs all stalls.

Parameters:
- NumLanes, 4: lanes per vector; also sets the drain length to NumLanes-1.
- DataWidth, 8: bits per lane element.
- FifoDepth, 4: input buffer entries; power of 2, ≥2.
- TileLenWidth, 8: width of the tile length field.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  start a tile; sampled only in IDLE.
- tile_len_i  in  TileLenWidth  vectors in the tile; captured on accepted start_i.
- busy_o  out  1  high in STREAM or DRAIN.
- done_o  out  1  one-cycle pulse when the tile completes.
- in_valid_i  in  1  input vector valid.
- in_ready_o  out  1  FIFO can accept a vector.
- in_data_i  in  NumLanes*DataWidth  input vector; lane k is bits [k*DataWidth +: DataWidth].
- out_valid_o  out  1  out_data_o carries a tile vector.
- out_data_o  out  NumLanes*DataWidth  vector to the skew chains; lane k feeds a chain of depth k.
- out_last_o  out  1  marks the final vector of the tile.

Behaviour:
- Reset:
  - rst_i high at a rising edge → state IDLE, FIFO emptied, counters cleared.
  - All outputs 0 except in_ready_o=1 (FIFO empty).
  - Reset mid-tile aborts the tile: no done_o, and buffered data is discarded.
- Input side:
  - in_ready_o = !fifo_full in every state, so prefetch during IDLE is allowed.
  - Push on in_valid_i && in_ready_o.
  - When full, ready stays low even if a pop occurs the same cycle (no pass-through).
- States: IDLE, STREAM, DRAIN.
- IDLE:
  - start_i=1 captures tile_len_i and clears the emit counter.
  - If tile_len_i != 0 → STREAM. If tile_len_i == 0 → DRAIN.
- STREAM:
  - Each cycle with FIFO non-empty: pop the head and register it onto out_data_o with out_valid_o=1 in the next cycle; increment the emit counter.
  - FIFO empty: bubble, out_valid_o=0, out_data_o=0.
  - Popping the vector that makes count == tile_len: out_last_o=1 alongside it, then → DRAIN.
  - Input-to-output latency is minimum 2 cycles: accepted at edge E, popped at E+1, visible after E+1.
- DRAIN:
  - Exactly NumLanes-1 cycles of out_data_o=0, out_valid_o=0, out_last_o=0.
  - After the last drain cycle: done_o=1 for one cycle, → IDLE.
  - With tile_len=0, DRAIN still runs its full NumLanes-1 cycles; no vectors are popped.
  - With NumLanes=1, DRAIN lasts 0 cycles and done_o follows the last-vector cycle.
- start_i outside IDLE is ignored, with no error.
- Vectors arriving beyond tile_len stay in the FIFO for the next tile.
- Outputs are fully registered; out_data_o is zero whenever out_valid_o=0.
- The emit counter is TileLenWidth bits; tile_len max 2^TileLenWidth-1, with no wrap.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy unchanged.

Decomposition:
- Package accel_feeder_pkg holds:
  - the state enum (IDLE, STREAM, DRAIN);
  - the lane_vec_t typedef (NumLanes x DataWidth packed);
  - a drain-count width constant, clog2(NumLanes) with a minimum of 1.
- One sub-module: sync_fifo (DataWidth*NumLanes wide, FifoDepth deep).
  - Ports: full/empty flags and a synchronous active-high reset.
- The FSM and counters live in the top module.

Test Plan:
- Basic tile:
  - Stimulus: NumLanes=4; push vectors 0x04030201, 0x08070605, 0x0C0B0A09 back-to-back, then start_i with tile_len=3.
  - Required response: three consecutive out_valid_o cycles with those values; out_last_o on 0x0C0B0A09; 3 zero drain cycles; done_o one cycle later; busy_o low afterwards.
- Starvation:
  - Stimulus: tile_len=2; push the second vector 5 cycles after the first.
  - Required response: out_valid_o=0 with data 0 during the gap; exactly 2 valid outputs; drain and done_o as normal.
- Backpressure:
  - Stimulus: FifoDepth=4; hold in_valid_i high in IDLE with no start.
  - Required response: in_ready_o drops after 4 accepts. After start_i (tile_len=6), ready reasserts and all 6 vectors are emitted in order with no loss or duplication.
- Zero length:
  - Stimulus: start_i with tile_len=0 and 2 vectors buffered.
  - Required response: no out_valid_o; done_o pulses after 3 drain cycles; the FIFO still holds 2 vectors.
- Reset mid-tile:
  - Stimulus: tile_len=5; assert rst_i after 2 vectors have been emitted.
  - Required response: next cycle all outputs are 0, in_ready_o=1, and no done_o. A fresh tile afterwards behaves as in the basic-tile scenario.
- Ignored start:
  - Stimulus: pulse start_i with tile_len=9 during STREAM of a tile_len=3 tile.
  - Required response: exactly 3 vectors are emitted and a single done_o pulse.
